// File: rtl/led_hit_detector_pkg.sv
// Shared definitions for the LED game: round state encoding, array-size defaults
// and the saturating adder used by the score counters.
package led_hit_detector_pkg;

    localparam int DEF_NUM_LEDS    = 10;
    localparam int DEF_SCORE_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } game_state_e;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// One push-button: synchroniser, debouncer and one-cycle rising-edge press pulse.
// A button already held when reset releases must be let go before it can press.
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_prev_q;
    logic                   armed_q, armed_d;
    logic                   press_q, press_d;
    logic                   sync_out_s;

    // Next-state: synchroniser shift, stability counter, arming and edge detect
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], button_raw};
        vld_d      = {vld_q[SYNC_STAGES-2:0], 1'b1};
        sync_out_s = sync_q[SYNC_STAGES-1];
        level_d    = level_q;
        cnt_d      = '0;
        if (sync_out_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_out_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
        // Arm only once a genuinely released button has been seen after reset.
        armed_d = armed_q | (vld_q[SYNC_STAGES-1] & ~sync_out_s & ~level_q);
        press_d = armed_q & level_q & ~level_prev_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            vld_q        <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            vld_q        <= vld_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            armed_q      <= armed_d;
            press_q      <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/led_hit_detector.sv
// Player-side round judge: conditions the buttons, scores presses against the lit
// LEDs, and runs the IDLE/ACTIVE/DONE round FSM with a bounded window.
module led_hit_detector
    import led_hit_detector_pkg::*;
#(
    parameter int NUM_LEDS        = DEF_NUM_LEDS,
    parameter int SCORE_WIDTH     = DEF_SCORE_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WINDOW_CYCLES   = 50000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   round_start,
    input  logic                   clear_score,
    input  logic [NUM_LEDS-1:0]    led,
    input  logic [NUM_LEDS-1:0]    button_raw,
    output logic [NUM_LEDS-1:0]    hit_mask,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [SCORE_WIDTH-1:0] misses,
    output logic                   round_active,
    output logic                   round_done
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_WIDTH) - 64'd1);

    logic [NUM_LEDS-1:0]    press_s, level_s, hits_s, wrong_s;
    game_state_e            state_q, state_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [NUM_LEDS-1:0]    hit_mask_q, hit_mask_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d, score_next_s;
    logic [SCORE_WIDTH-1:0] misses_q, misses_d, misses_next_s;
    logic                   hit_pulse_q, hit_pulse_d;
    logic                   miss_pulse_q, miss_pulse_d;
    logic                   round_active_q, round_done_q;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_btn
        button_conditioner #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn (
            .clk        (clk),
            .reset      (reset),
            .button_raw (button_raw[i]),
            .level      (level_s[i]),
            .press      (press_s[i])
        );
    end

    // Round FSM, hit classification and saturating counters
    always_comb begin
        hits_s        = press_s & led & ~hit_mask_q;
        wrong_s       = press_s & ~led;
        state_d       = state_q;
        win_d         = win_q;
        hit_mask_d    = hit_mask_q;
        score_next_s  = score_q;
        misses_next_s = misses_q;
        hit_pulse_d   = 1'b0;
        miss_pulse_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (round_start) begin
                    state_d    = ST_ACTIVE;
                    win_d      = WIN_LOAD;
                    hit_mask_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (round_start) begin
                    win_d      = WIN_LOAD;
                    hit_mask_d = '0;
                end else begin
                    hit_mask_d    = hit_mask_q | hits_s;
                    score_next_s  = SCORE_WIDTH'(sat_add(32'(score_q),
                                        32'($countones(hits_s)), SCORE_MAX));
                    misses_next_s = SCORE_WIDTH'(sat_add(32'(misses_q),
                                        32'($countones(wrong_s)), SCORE_MAX));
                    hit_pulse_d   = |hits_s;
                    miss_pulse_d  = |wrong_s;
                    win_d         = (win_q != '0) ? (win_q - WIN_W'(1)) : win_q;
                    // A final hit in the expiring cycle is already folded into hit_mask_d.
                    if ((win_q == '0) || ((|led) && ((led & ~hit_mask_d) == '0))) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        score_d  = clear_score ? '0 : score_next_s;
        misses_d = clear_score ? '0 : misses_next_s;
    end

    // Registered state and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            win_q          <= '0;
            hit_mask_q     <= '0;
            score_q        <= '0;
            misses_q       <= '0;
            hit_pulse_q    <= 1'b0;
            miss_pulse_q   <= 1'b0;
            round_active_q <= 1'b0;
            round_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            hit_mask_q     <= hit_mask_d;
            score_q        <= score_d;
            misses_q       <= misses_d;
            hit_pulse_q    <= hit_pulse_d;
            miss_pulse_q   <= miss_pulse_d;
            round_active_q <= (state_d == ST_ACTIVE);
            round_done_q   <= (state_d == ST_DONE);
        end
    end

    assign hit_mask     = hit_mask_q;
    assign hit_pulse    = hit_pulse_q;
    assign miss_pulse   = miss_pulse_q;
    assign score        = score_q;
    assign misses       = misses_q;
    assign round_active = round_active_q;
    assign round_done   = round_done_q;

endmodule

// File: tb/tb_led_hit_detector.sv
// Directed bench for led_hit_detector with a 4-LED, short-debounce, 100-cycle-window build.
module tb_led_hit_detector;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset, round_start, clear_score;
    logic [N-1:0] led, button_raw, hit_mask;
    logic         hit_pulse, miss_pulse, round_active, round_done;
    logic [7:0]   score, misses;

    int errors = 0;
    int checks = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    int n_done;

    always #5 clk = ~clk;

    led_hit_detector #(
        .NUM_LEDS        (N),
        .SCORE_WIDTH     (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .WINDOW_CYCLES   (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .round_start  (round_start),
        .clear_score  (clear_score),
        .led          (led),
        .button_raw   (button_raw),
        .hit_mask     (hit_mask),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .score        (score),
        .misses       (misses),
        .round_active (round_active),
        .round_done   (round_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            if (hit_pulse)  hit_cnt++;
            if (miss_pulse) miss_cnt++;
        end
    endtask

    task automatic start_round();
        round_start = 1'b1;
        step();
        round_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; round_start = 1'b0; clear_score = 1'b0;
        led = 4'b0000; button_raw = 4'b0000;
        run(3);
        check("rst_score", score, 0);
        check("rst_misses", misses, 0);
        check("rst_mask", hit_mask, 0);
        check("rst_active", round_active, 0);
        check("rst_done", round_done, 0);
        reset = 1'b0;
        run(5);

        // Basic hit: press reaches hit_pulse 8 cycles after the raw rise
        start_round();
        check("basic_active", round_active, 1);
        led = 4'b0100;
        button_raw = 4'b0100;
        run(7);
        check("basic_no_early_hit", hit_pulse, 0);
        run(1);
        check("basic_hit_pulse", hit_pulse, 1);
        check("basic_score", score, 1);
        check("basic_mask", hit_mask, 4'b0100);
        check("basic_done", round_done, 1);
        run(1);
        check("basic_done_one_cycle", round_done, 0);
        check("basic_idle", round_active, 0);
        check("basic_mask_held", hit_mask, 4'b0100);
        button_raw = 4'b0000;
        run(10);

        clear_score = 1'b1;
        step();
        clear_score = 1'b0;
        check("clear_score", score, 0);

        // Wrong press and repeat press
        start_round();
        check("new_round_mask", hit_mask, 0);
        led = 4'b0011;
        button_raw = 4'b1000; run(8);
        check("wrong_pulse", miss_pulse, 1);
        check("wrong_misses", misses, 1);
        check("wrong_score", score, 0);
        button_raw = 4'b0000; run(10);
        button_raw = 4'b0001; run(8);
        check("first_press_score", score, 1);
        button_raw = 4'b0000; run(10);
        hit_cnt = 0; miss_cnt = 0;
        button_raw = 4'b0001; run(8);
        check("repeat_no_hit", hit_cnt, 0);
        check("repeat_no_miss", miss_cnt, 0);
        check("repeat_score", score, 1);
        check("repeat_active", round_active, 1);
        button_raw = 4'b0000; run(10);
        button_raw = 4'b0010; run(8);
        check("all_hit_score", score, 2);
        check("all_hit_done", round_done, 1);
        button_raw = 4'b0000; run(10);

        // Bounce on button 1
        start_round();
        led = 4'b0010;
        hit_cnt = 0; miss_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            button_raw[1] = ~button_raw[1];
            run(2);
        end
        button_raw[1] = 1'b1;
        run(15);
        check("bounce_hits", hit_cnt, 1);
        check("bounce_misses", miss_cnt, 0);
        check("bounce_score", score, 3);
        button_raw = 4'b0000; run(10);

        // Timeout with no presses
        led = 4'b1111;
        start_round();
        n_done = 0;
        for (int k = 1; k <= 150; k++) begin
            step();
            if (round_done) begin
                n_done = k;
                break;
            end
        end
        check("timeout_len", n_done, 100);
        check("timeout_mask", hit_mask, 0);
        run(3);

        // Saturation via 4-bit simultaneous presses, 4 points per round
        clear_score = 1'b1; step(); clear_score = 1'b0;
        for (int r = 0; r < 65; r++) begin
            start_round();
            button_raw = 4'b1111;
            run(8);
            if (r == 0) check("multi_bit_score", score, 4);
            if (r == 63) check("sat_reached", score, 255);
            button_raw = 4'b0000;
            run(10);
        end
        check("sat_held", score, 255);

        // Two-bit hit coincident with clear_score
        start_round();
        led = 4'b0011;
        button_raw = 4'b0011;
        run(7);
        clear_score = 1'b1;
        run(1);
        clear_score = 1'b0;
        check("clear_wins_score", score, 0);
        check("clear_wins_mask", hit_mask, 4'b0011);
        button_raw = 4'b0000; run(10);

        // Hit in the last window cycle
        start_round();
        run(92);
        button_raw = 4'b0001;
        run(7);
        check("last_cycle_active", round_active, 1);
        check("last_cycle_no_done", round_done, 0);
        run(1);
        check("last_cycle_hit", hit_pulse, 1);
        check("last_cycle_score", score, 1);
        check("last_cycle_done", round_done, 1);
        button_raw = 4'b0000; run(10);

        // Reset mid-round while a button is held
        start_round();
        led = 4'b0001;
        button_raw = 4'b0010;
        run(10);
        check("pre_reset_misses", misses, 1);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        check("midrst_score", score, 0);
        check("midrst_misses", misses, 0);
        check("midrst_active", round_active, 0);
        check("midrst_mask", hit_mask, 0);
        run(3);
        start_round();
        led = 4'b0010;
        hit_cnt = 0; miss_cnt = 0;
        run(30);
        check("held_no_hit", hit_cnt, 0);
        check("held_no_miss", miss_cnt, 0);
        button_raw = 4'b0000; run(10);
        button_raw = 4'b0010; run(8);
        check("repress_hit", hit_pulse, 1);
        check("repress_score", score, 1);
        button_raw = 4'b0000; run(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
